stream_demux_1to2: RTL and testbench
====================================

# stream_demux_1to2

Registered 1-to-2 stream demultiplexer with valid/ready handshaking on the input and on each output. It routes each accepted word to one of two output channels according to a per-word destination bit. Each output channel has a single-entry holding register, so routed data is clocked and back-pressure is honoured. The block sits in front of the combinational 1-to-2 demux datapath and replaces it wherever consumers can stall. It also keeps a per-channel count of delivered words.

## Interface
- WIDTH, 8, data width in bits
- CNT_W, 8, width of each per-channel delivery counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock, reset sampled on rising edge of clk
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts word this cycle
- in_data  input  WIDTH  upstream word
- in_dest  input  1  destination: 0 → channel 0, 1 → channel 1
- out0_valid  output  1  channel 0 holding register occupied
- out0_ready  input  1  channel 0 consumer accepts
- out0_data  output  WIDTH  channel 0 word
- out1_valid  output  1  channel 1 holding register occupied
- out1_ready  input  1  channel 1 consumer accepts
- out1_data  output  WIDTH  channel 1 word
- cnt0  output  CNT_W  words delivered on channel 0 (out0_valid & out0_ready), modulo 2^CNT_W
- cnt1  output  CNT_W  words delivered on channel 1, modulo 2^CNT_W

## Operation
- Per channel k, two states:
  - EMPTY: outk_valid=0.
  - FULL: outk_valid=1, outk_data stable.
- Input handshake: accept occurs when in_valid & in_ready.
- in_ready = (in_dest==0) ? (~out0_valid | out0_ready) : (~out1_valid | out1_ready).
  - in_ready depends combinationally on in_dest and the selected channel's ready.
  - It is independent of the non-selected channel.
- Channel k transitions:
  - EMPTY → FULL: on accept with in_dest==k; outk_data ← in_data.
  - FULL → EMPTY: on outk_ready with no accept targeting k.
  - FULL → FULL, new data: on outk_ready together with an accept targeting k (pass-through; no bubble).
  - FULL, no outk_ready: hold outk_data unchanged; in_ready=0 for words targeting k.
- Non-targeted channel: its data register is never written, and its valid changes only via its own drain.
- Counters:
  - cntk increments by 1 in each cycle where outk_valid & outk_ready.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
  - Counts delivered words, not accepted words.
- A stalled channel blocks only words addressed to it. Words for the other channel flow freely (no head-of-line coupling between channels, since there is no shared buffer).
- outk_data while outk_valid=0: holds the last value written, or 0 after reset; consumers must ignore it.

## Timing
- Reset (rst_n=0 at a rising edge), effective next cycle:
  - out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0.
  - in_ready follows its equation (1 after reset, since both channels are EMPTY).
- Reset mid-operation: words in holding registers are discarded and not counted. An accept or delivery in the reset cycle has no effect.
- Latency: a word accepted at edge N is visible on outk_data with outk_valid=1 after edge N, and can be delivered at edge N+1.
- Throughput: 1 word/cycle per channel with outk_ready held high. Back-to-back words to alternating channels also sustain 1 word/cycle.
- Simultaneous drain of k and accept to k: counter increments, data is replaced, valid stays 1.
- Simultaneous drain on both channels: both counters increment in the same cycle.
- No combinational path from in_valid to any output valid or data.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out0_valid=out1_valid=0, data=0, cnt0=cnt1=0, in_ready=1 after release.
- Basic routing, both readies=1:
  - Send 0xA5 dest0 → out0_data=0xA5, out0_valid=1 one cycle later; out1_valid stays 0.
  - Then send 0x3C dest1 → out1_data=0x3C; cnt0=1, cnt1=1 after delivery.
- Back-pressure:
  - out0_ready=0; send 0x11 dest0 → accepted.
  - Offer 0x22 dest0 → in_ready=0 until out0_ready=1.
  - Meanwhile 0x33 dest1 is accepted and delivered.
  - On release, 0x11 is delivered, then 0x22; order is preserved.
- Streaming: 16 words alternating dest 0/1 with both readies high → one accept per cycle, cnt0=8, cnt1=8, no bubbles.
- Wrap-around: CNT_W=8, deliver 257 words on channel 1 → cnt1=1, cnt0=0.
- Reset mid-stream: channel 0 FULL with 0x77 and out0_ready=0; assert rst_n=0 → out0_valid=0 next cycle, cnt0=0, 0x77 never delivered.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
//
// Registered 1-to-2 stream demultiplexer. Each accepted input word is steered
// by in_dest into one of two single-entry holding registers; each output
// channel then presents the word with its own valid/ready handshake. A stalled
// channel only blocks words addressed to it. Each channel also counts the
// words it has delivered (modulo 2^CNT_W).
//
// Parameters
//   WIDTH  data width in bits
//   CNT_W  width of each per-channel delivery counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    upstream word present
//   in_ready    block accepts the word this cycle (depends on in_dest)
//   in_data     upstream word
//   in_dest     destination channel (0 or 1)
//   out0_valid  channel 0 holding register occupied
//   out0_ready  channel 0 consumer accepts
//   out0_data   channel 0 word
//   out1_valid  channel 1 holding register occupied
//   out1_ready  channel 1 consumer accepts
//   out1_data   channel 1 word
//   cnt0        words delivered on channel 0
//   cnt1        words delivered on channel 1
// -----------------------------------------------------------------------------
module stream_demux_1to2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dest,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  // Per-channel views so both channels share one generate body.
  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic [WIDTH-1:0] data_vec [2];
  logic [CNT_W-1:0] cnt_vec  [2];
  logic             accept;

  assign ready_vec = {out1_ready, out0_ready};

  // Only the addressed channel gates the input; the other channel's state is
  // irrelevant, which is what prevents head-of-line coupling. A full channel
  // that is draining this cycle can take a new word (pass-through, no bubble).
  assign in_ready = in_dest ? (~valid_vec[1] | ready_vec[1])
                            : (~valid_vec[0] | ready_vec[0]);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      chan_state_t      state_reg;
      logic [WIDTH-1:0] data_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             take;
      logic             drain;

      assign take  = accept & (in_dest == 1'(gi));
      assign drain = (state_reg == FULL) & ready_vec[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (take) begin
                state_reg <= FULL;
                data_reg  <= in_data;
              end
            end
            FULL: begin
              // take implies the consumer is draining this cycle, so the
              // register is refilled and stays FULL.
              if (take) begin
                data_reg <= in_data;
              end else if (ready_vec[gi]) begin
                state_reg <= EMPTY;
              end
            end
            default: state_reg <= EMPTY;
          endcase

          // Counts deliveries, not accepts; wraps silently.
          if (drain) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign valid_vec[gi] = (state_reg == FULL);
      assign data_vec[gi]  = data_reg;
      assign cnt_vec[gi]   = cnt_reg;
    end
  endgenerate

  assign out0_valid = valid_vec[0];
  assign out1_valid = valid_vec[1];
  assign out0_data  = data_vec[0];
  assign out1_data  = data_vec[1];
  assign cnt0       = cnt_vec[0];
  assign cnt1       = cnt_vec[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1to2
//
// Directed bench for stream_demux_1to2 (WIDTH=8, CNT_W=8). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same offset, so nothing
// is observed at the active edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_1to2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dest;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int passed = 0;
  int total  = 0;

  stream_demux_1to2 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with traffic offered ----------------
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_dest = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick(); tick();
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", 32'(out0_data), 32'd0);
    chk("rst_d1", 32'(out1_data), 32'd0);
    chk("rst_c0", 32'(cnt0), 32'd0);
    chk("rst_c1", 32'(cnt1), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);

    // ---------------- basic routing ----------------
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 1'b0;
    #1;
    chk("b_rdy0", 32'(in_ready), 32'd1);
    tick();
    chk("b_v0", 32'(out0_valid), 32'd1);
    chk("b_d0", 32'(out0_data), 32'hA5);
    chk("b_v1", 32'(out1_valid), 32'd0);
    in_data = 8'h3C; in_dest = 1'b1;
    tick();
    chk("b_v0_drained", 32'(out0_valid), 32'd0);
    chk("b_c0", 32'(cnt0), 32'd1);
    chk("b_v1b", 32'(out1_valid), 32'd1);
    chk("b_d1", 32'(out1_data), 32'h3C);
    in_valid = 1'b0;
    tick();
    chk("b_v1_drained", 32'(out1_valid), 32'd0);
    chk("b_c1", 32'(cnt1), 32'd1);

    // ---------------- back-pressure ----------------
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; in_dest = 1'b0;
    #1;
    chk("bp_rdy_11", 32'(in_ready), 32'd1);
    tick();
    chk("bp_v0_11", 32'(out0_valid), 32'd1);
    chk("bp_d0_11", 32'(out0_data), 32'h11);
    in_data = 8'h22;
    #1;
    chk("bp_rdy_22_blk", 32'(in_ready), 32'd0);
    tick();
    chk("bp_d0_hold", 32'(out0_data), 32'h11);
    chk("bp_c0_hold", 32'(cnt0), 32'd1);
    in_data = 8'h33; in_dest = 1'b1;
    #1;
    chk("bp_rdy_33", 32'(in_ready), 32'd1);
    tick();
    chk("bp_v1_33", 32'(out1_valid), 32'd1);
    chk("bp_d1_33", 32'(out1_data), 32'h33);
    chk("bp_d0_still", 32'(out0_data), 32'h11);
    in_data = 8'h22; in_dest = 1'b0;
    #1;
    chk("bp_rdy_22_blk2", 32'(in_ready), 32'd0);
    tick();
    chk("bp_c1_33", 32'(cnt1), 32'd2);
    chk("bp_v1_drained", 32'(out1_valid), 32'd0);
    out0_ready = 1'b1;
    #1;
    chk("bp_rdy_22_open", 32'(in_ready), 32'd1);
    tick();
    chk("bp_c0_11", 32'(cnt0), 32'd2);
    chk("bp_v0_pass", 32'(out0_valid), 32'd1);
    chk("bp_d0_22", 32'(out0_data), 32'h22);
    in_valid = 1'b0;
    tick();
    chk("bp_c0_22", 32'(cnt0), 32'd3);
    chk("bp_v0_empty", 32'(out0_valid), 32'd0);

    // ---------------- streaming, alternating destinations ----------------
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i); in_dest = 1'(i % 2);
      #1;
      chk($sformatf("st_rdy_%0d", i), 32'(in_ready), 32'd1);
      tick();
      if (i % 2 == 0) begin
        chk($sformatf("st_d0_%0d", i), {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'(8'h40 + i)});
      end else begin
        chk($sformatf("st_d1_%0d", i), {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'(8'h40 + i)});
      end
    end
    in_valid = 1'b0;
    tick();
    chk("st_c0", 32'(cnt0), 32'd11);
    chk("st_c1", 32'(cnt1), 32'd10);
    chk("st_v0", 32'(out0_valid), 32'd0);
    chk("st_v1", 32'(out1_valid), 32'd0);

    // ---------------- counter wrap on channel 1 ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("wr_c1_rst", 32'(cnt1), 32'd0);
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_dest = 1'b1;
      #1;
      if (in_ready !== 1'b1) chk($sformatf("wr_rdy_%0d", i), 32'(in_ready), 32'd1);
      tick();
      if (i == 255) chk("wr_c1_255", 32'(cnt1), 32'd255);
    end
    in_valid = 1'b0;
    tick();
    chk("wr_c1", 32'(cnt1), 32'd1);
    chk("wr_c0", 32'(cnt0), 32'd0);
    chk("wr_v1", 32'(out1_valid), 32'd0);

    // ---------------- reset mid-stream ----------------
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; in_dest = 1'b0;
    tick();
    chk("mr_v0_77", 32'(out0_valid), 32'd1);
    chk("mr_d0_77", 32'(out0_data), 32'h77);
    // Delivery and a fresh accept both land in the reset cycle; neither counts.
    rst_n = 1'b0; out0_ready = 1'b1; in_data = 8'h99;
    tick();
    chk("mr_v0", 32'(out0_valid), 32'd0);
    chk("mr_d0", 32'(out0_data), 32'd0);
    chk("mr_c0", 32'(cnt0), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("mr_c0_after", 32'(cnt0), 32'd0);
    chk("mr_v0_after", 32'(out0_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
